// File: rtl/rdwr_strobe_sequencer_if.sv
// Request/strobe bundle between the rd/wr strobe sequencer and its requester.
// Pending-count widths follow the queue depths; instantiate with matching parameters.
`timescale 1ns/1ps
interface rdwr_strobe_sequencer_if #(
  parameter int RD_QDEPTH = 4,
  parameter int WR_QDEPTH = 4
);
  logic                           start;
  logic                           rd_req;
  logic                           wr_req;
  logic                           rd;
  logic                           wr;
  logic [$clog2(RD_QDEPTH+1)-1:0] rd_pend;
  logic [$clog2(WR_QDEPTH+1)-1:0] wr_pend;
  logic                           busy;
  logic                           ovf;

  modport master (
    output start, rd_req, wr_req,
    input  rd, wr, rd_pend, wr_pend, busy, ovf
  );

  modport slave (
    input  start, rd_req, wr_req,
    output rd, wr, rd_pend, wr_pend, busy, ovf
  );
endinterface

// File: rtl/rdwr_strobe_sequencer.sv
// Queues rd/wr request pulses and issues RD_LEN-cycle rd bursts and 1-cycle wr strobes.
// Define RDWR_GAP_EN to insert a 1-cycle GAP state after every rd burst.
`timescale 1ns/1ps
module rdwr_strobe_sequencer #(
  parameter int RD_LEN    = 2,
  parameter int RD_QDEPTH = 4,
  parameter int WR_QDEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  rdwr_strobe_sequencer_if.slave bus
);

  localparam int RPW = $clog2(RD_QDEPTH + 1);
  localparam int WPW = $clog2(WR_QDEPTH + 1);
  localparam int BCW = $clog2(RD_LEN);
  localparam logic [RPW-1:0] RD_FULL    = RPW'(RD_QDEPTH);
  localparam logic [WPW-1:0] WR_FULL    = WPW'(WR_QDEPTH);
  localparam logic [BCW-1:0] BURST_LAST = BCW'(RD_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
`ifdef RDWR_GAP_EN
    S_WR,
    S_GAP
`else
    S_WR
`endif
  } state_t;

  state_t         state, state_next;
  logic [BCW-1:0] burst_cnt, burst_cnt_next;
  logic [RPW-1:0] rd_cnt;
  logic [WPW-1:0] wr_cnt;
  logic           rd_grant, wr_grant;
  logic           rd_drop, wr_drop;
  logic           rd_q, wr_q, busy_q, ovf_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next     = state;
    burst_cnt_next = burst_cnt;
    rd_grant       = 1'b0;
    wr_grant       = 1'b0;
    case (state)
      S_IDLE: begin
        burst_cnt_next = '0;
        if (bus.start && rd_cnt != '0) begin
          state_next = S_RD;
          rd_grant   = 1'b1;
        end else if (bus.start && wr_cnt != '0) begin
          state_next = S_WR;
          wr_grant   = 1'b1;
        end
      end
      S_RD: begin
        if (burst_cnt == BURST_LAST) begin
          burst_cnt_next = '0;
`ifdef RDWR_GAP_EN
          state_next     = S_GAP;
`else
          state_next     = S_IDLE;
`endif
        end else begin
          burst_cnt_next = burst_cnt + 1'b1;
        end
      end
      S_WR:    state_next = S_IDLE;
`ifdef RDWR_GAP_EN
      S_GAP:   state_next = S_IDLE;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // A full queue still accepts a request when a grant frees a slot on the same edge.
  assign rd_drop = bus.rd_req && (rd_cnt == RD_FULL) && !rd_grant;
  assign wr_drop = bus.wr_req && (wr_cnt == WR_FULL) && !wr_grant;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      burst_cnt <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state     <= state_next;
      burst_cnt <= burst_cnt_next;

      if (bus.rd_req && !rd_drop && !rd_grant) rd_cnt <= rd_cnt + 1'b1;
      else if (!bus.rd_req && rd_grant)        rd_cnt <= rd_cnt - 1'b1;

      if (bus.wr_req && !wr_drop && !wr_grant) wr_cnt <= wr_cnt + 1'b1;
      else if (!bus.wr_req && wr_grant)        wr_cnt <= wr_cnt - 1'b1;

      // Strobes are flops loaded from the next state, so they are glitch-free.
      rd_q   <= (state_next == S_RD);
      wr_q   <= (state_next == S_WR);
      busy_q <= (state_next != S_IDLE);
      ovf_q  <= rd_drop | wr_drop;
    end
  end

  assign bus.rd      = rd_q;
  assign bus.wr      = wr_q;
  assign bus.busy    = busy_q;
  assign bus.ovf     = ovf_q;
  assign bus.rd_pend = rd_cnt;
  assign bus.wr_pend = wr_cnt;

endmodule

// File: tb/tb_rdwr_strobe_sequencer.sv
// Directed bench: stimulus pushes expected strobe events (kind, edge index) into a
// scoreboard; a negedge monitor pops and compares whenever rd rises or wr is high.
`timescale 1ns/1ps
module tb_rdwr_strobe_sequencer;

  localparam int RD_LEN    = 2;
  localparam int RD_QDEPTH = 4;
  localparam int WR_QDEPTH = 4;
`ifdef RDWR_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rdwr_strobe_sequencer_if #(.RD_QDEPTH(RD_QDEPTH), .WR_QDEPTH(WR_QDEPTH)) bus ();

  rdwr_strobe_sequencer #(
    .RD_LEN   (RD_LEN),
    .RD_QDEPTH(RD_QDEPTH),
    .WR_QDEPTH(WR_QDEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef enum int {K_RD = 1, K_WR = 2} kind_e;
  typedef struct {
    kind_e kind;
    int    cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_miss = 0;

  // cyc equals the index of the most recent posedge when sampled at negedge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_rd"},      32'(bus.rd),      0);
    check({tag, "_wr"},      32'(bus.wr),      0);
    check({tag, "_busy"},    32'(bus.busy),    0);
    check({tag, "_ovf"},     32'(bus.ovf),     0);
    check({tag, "_rd_pend"}, 32'(bus.rd_pend), 0);
    check({tag, "_wr_pend"}, 32'(bus.wr_pend), 0);
  endtask

  task automatic strobe_event(input kind_e k);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL unexpected_strobe: got kind %0d expected none (edge %0d)", int'(k), cyc);
    end else begin
      e = sb.pop_front();
      check("strobe_kind",     32'(int'(k)), 32'(int'(e.kind)));
      check("strobe_edge",     32'(cyc),     32'(e.cyc));
      check("rd_wr_exclusive", 32'(bus.rd & bus.wr), 0);
    end
  endtask

  // Monitor
  logic prev_rd   = 1'b0;
  int   burst_len = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_rd   = 1'b0;
      burst_len = 0;
    end else begin
      if (bus.rd && !prev_rd) begin
        strobe_event(K_RD);
        burst_len = 0;
      end
      if (bus.rd) burst_len++;
      if (!bus.rd && prev_rd) check("rd_burst_len", 32'(burst_len), 32'(RD_LEN));
      if (bus.wr) strobe_event(K_WR);
      prev_rd = bus.rd;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Stimulus
  int e;
  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.rd_req = 1'b1;
    bus.wr_req = 1'b0;

    // 1. reset held with rd_req asserted
    repeat (3) step();
    chk_zero("t1_in_reset");
    rst        = 1'b0;
    bus.rd_req = 1'b0;
    step();
    chk_zero("t1_post_reset");

    // 2. single read, strobe one edge after the request
    bus.start  = 1'b1;
    bus.rd_req = 1'b1;
    e = cyc + 1;
    sb.push_back('{kind: K_RD, cyc: e + 1});
    step();
    bus.rd_req = 1'b0;
    check("t2_rd_pend_at_req", 32'(bus.rd_pend), 1);
    check("t2_rd_before_grant", 32'(bus.rd), 0);
    step();
    check("t2_rd_pend_at_grant", 32'(bus.rd_pend), 0);
    check("t2_rd_high", 32'(bus.rd), 1);
    check("t2_busy", 32'(bus.busy), 1);
    repeat (4) step();
    check("t2_idle_busy", 32'(bus.busy), 0);

    // 3. read priority over a same-edge write
    bus.rd_req = 1'b1;
    bus.wr_req = 1'b1;
    e = cyc + 1;
    sb.push_back('{kind: K_RD, cyc: e + 1});
    sb.push_back('{kind: K_WR, cyc: e + 4 + GAP});
    step();
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    check("t3_rd_pend", 32'(bus.rd_pend), 1);
    check("t3_wr_pend", 32'(bus.wr_pend), 1);
    repeat (8) step();
    check("t3_wr_pend_drained", 32'(bus.wr_pend), 0);
    check("t3_busy", 32'(bus.busy), 0);

    // 4. write overflow with start low, then a request on the first grant edge
    bus.start  = 1'b0;
    bus.wr_req = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("t4_wr_pend_%0d", i), 32'(bus.wr_pend), 32'((i < WR_QDEPTH) ? i : WR_QDEPTH));
      check($sformatf("t4_ovf_%0d", i), 32'(bus.ovf), 32'((i == 5) ? 1 : 0));
    end
    bus.start = 1'b1;
    e = cyc;
    for (int i = 0; i < 5; i++) sb.push_back('{kind: K_WR, cyc: e + 1 + 2 * i});
    step();
    bus.wr_req = 1'b0;
    check("t4_ovf_single_pulse", 32'(bus.ovf), 0);
    check("t4_wr_pend_req_and_grant", 32'(bus.wr_pend), 4);
    check("t4_wr_high", 32'(bus.wr), 1);
    repeat (10) step();
    check("t4_wr_pend_drained", 32'(bus.wr_pend), 0);
    check("t4_busy", 32'(bus.busy), 0);

    // 5. start dropped during the burst; a request queued mid-burst stays pending
    bus.rd_req = 1'b1;
    e = cyc + 1;
    sb.push_back('{kind: K_RD, cyc: e + 1});
    step();
    bus.rd_req = 1'b0;
    step();
    bus.start  = 1'b0;
    bus.rd_req = 1'b1;
    step();
    bus.rd_req = 1'b0;
    check("t5_rd_second_cycle", 32'(bus.rd), 1);
    check("t5_rd_pend_queued", 32'(bus.rd_pend), 1);
    repeat (6) step();
    check("t5_rd_pend_held", 32'(bus.rd_pend), 1);
    check("t5_busy", 32'(bus.busy), 0);
    check("t5_rd_low", 32'(bus.rd), 0);

    // 6. asynchronous reset in the middle of a burst
    bus.start  = 1'b1;
    bus.wr_req = 1'b1;
    e = cyc;
    sb.push_back('{kind: K_RD, cyc: e + 1});
    step();
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b1;
    check("t6_rd_high", 32'(bus.rd), 1);
    check("t6_wr_pend", 32'(bus.wr_pend), 1);
    step();
    bus.rd_req = 1'b0;
    check("t6_rd_pend", 32'(bus.rd_pend), 1);
    #1 rst = 1'b1;
    #1;
    check("t6_async_rd", 32'(bus.rd), 0);
    check("t6_async_busy", 32'(bus.busy), 0);
    check("t6_async_rd_pend", 32'(bus.rd_pend), 0);
    check("t6_async_wr_pend", 32'(bus.wr_pend), 0);
    step();
    rst = 1'b0;
    repeat (6) step();
    chk_zero("t6_after_reset");

    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
